// File: rtl/pic_priority_sequencer.sv
// Interrupt sequencer: latches IR requests, resolves fixed/rotating priority
// against the in-service register, runs the two-pulse INTA sequence and EOI.
module pic_priority_sequencer #(
  parameter int SPURIOUS_LEVEL = 7
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] ir_req,
  input  logic [7:0] irr_mask,
  input  logic       inta_pulse,
  input  logic       eoi_valid,
  input  logic       eoi_specific,
  input  logic [2:0] eoi_level,
  input  logic       aeoi_en,
  input  logic       rotate_en,
  input  logic [4:0] vector_base,
  output logic       int_out,
  output logic [7:0] vector_out,
  output logic       vector_valid,
  output logic [7:0] isr,
  output logic [7:0] irr,
  output logic [1:0] dbg_state,
  output logic [2:0] dbg_lowest_prio
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2
  } state_t;

  localparam logic [2:0] SPUR_LVL = 3'(SPURIOUS_LEVEL);

  state_t     state_q;
  logic [7:0] irr_q, isr_q, vec_q;
  logic       int_q, vval_q, spur_q;
  logic [2:0] lp_q, grant_q;

  logic [7:0] cand;
  logic       win_found, win_blocked;
  logic [2:0] win_lvl;
  logic       isr_hi_found;
  logic [2:0] isr_hi_lvl;
  logic [2:0] scan_lvl;
  logic       eoi_hit;
  logic [2:0] eoi_lvl;
  logic [7:0] eoi_clr;

  // Walk levels from highest to lowest priority under the current rotation.
  // A set ISR bit met before (or at) the first candidate blocks it.
  always_comb begin
    cand         = irr_q & irr_mask;
    win_found    = 1'b0;
    win_blocked  = 1'b0;
    win_lvl      = 3'd0;
    isr_hi_found = 1'b0;
    isr_hi_lvl   = 3'd0;
    scan_lvl     = 3'd0;
    for (int k = 0; k < 8; k++) begin
      scan_lvl = lp_q + 3'(k) + 3'd1;
      if (!win_found && !win_blocked) begin
        if (isr_q[scan_lvl]) begin
          win_blocked = 1'b1;
        end else if (cand[scan_lvl]) begin
          win_found = 1'b1;
          win_lvl   = scan_lvl;
        end
      end
      if (!isr_hi_found && isr_q[scan_lvl]) begin
        isr_hi_found = 1'b1;
        isr_hi_lvl   = scan_lvl;
      end
    end
    eoi_hit = eoi_valid && (eoi_specific || isr_hi_found);
    eoi_lvl = eoi_specific ? eoi_level : isr_hi_lvl;
    eoi_clr = eoi_hit ? (8'b1 << eoi_lvl) : 8'b0;
  end

  // EOI applies every cycle on the pre-update ISR; the state-specific
  // branches below layer the INTA set or AEOI clear on top of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      irr_q   <= 8'h00;
      isr_q   <= 8'h00;
      vec_q   <= 8'h00;
      int_q   <= 1'b0;
      vval_q  <= 1'b0;
      spur_q  <= 1'b0;
      lp_q    <= 3'd7;
      grant_q <= 3'd0;
    end else begin
      irr_q  <= ir_req;
      vval_q <= 1'b0;
      isr_q  <= isr_q & ~eoi_clr;
      if (eoi_hit && rotate_en) lp_q <= eoi_lvl;
      case (state_q)
        ST_IDLE: begin
          if (win_found) begin
            int_q   <= 1'b1;
            state_q <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (inta_pulse) begin
            grant_q <= win_found ? win_lvl : SPUR_LVL;
            spur_q  <= !win_found;
            if (win_found) begin
              isr_q <= (isr_q & ~eoi_clr) | (8'b1 << win_lvl);
              irr_q <= ir_req & ~(8'b1 << win_lvl);
            end
            int_q   <= 1'b0;
            state_q <= ST_ACK1;
          end
        end
        ST_ACK1: begin
          if (inta_pulse) begin
            vec_q   <= {vector_base, grant_q};
            vval_q  <= 1'b1;
            state_q <= ST_IDLE;
            if (aeoi_en && !spur_q) begin
              isr_q <= isr_q & ~eoi_clr & ~(8'b1 << grant_q);
              if (rotate_en && !eoi_hit) lp_q <= grant_q;
            end
          end
        end
        default: begin
          int_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign int_out         = int_q;
  assign vector_out      = vec_q;
  assign vector_valid    = vval_q;
  assign isr             = isr_q;
  assign irr             = irr_q;
  assign dbg_state       = state_q;
  assign dbg_lowest_prio = lp_q;

endmodule

// File: tb/tb_pic_priority_sequencer.sv
// Bench for pic_priority_sequencer: directed vector table, hand sequences for
// spurious/AEOI/rotation/reset, then random traffic against a rank-based model.
module tb_pic_priority_sequencer;

  localparam logic [4:0] BASE = 5'h0A;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] ir_req, irr_mask;
  logic       inta_pulse, eoi_valid, eoi_specific, aeoi_en, rotate_en;
  logic [2:0] eoi_level;
  logic [4:0] vector_base;
  logic       int_out, vector_valid;
  logic [7:0] vector_out, isr, irr;
  logic [1:0] dbg_state;
  logic [2:0] dbg_lowest_prio;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pic_priority_sequencer #(.SPURIOUS_LEVEL(7)) dut (
    .clk(clk), .reset_n(reset_n), .ir_req(ir_req), .irr_mask(irr_mask),
    .inta_pulse(inta_pulse), .eoi_valid(eoi_valid), .eoi_specific(eoi_specific),
    .eoi_level(eoi_level), .aeoi_en(aeoi_en), .rotate_en(rotate_en),
    .vector_base(vector_base), .int_out(int_out), .vector_out(vector_out),
    .vector_valid(vector_valid), .isr(isr), .irr(irr),
    .dbg_state(dbg_state), .dbg_lowest_prio(dbg_lowest_prio)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inta_pulse   = 1'b0;
    eoi_valid    = 1'b0;
    eoi_specific = 1'b0;
    eoi_level    = 3'd0;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    idle_inputs();
    #2;
    chk({tag, " rst int"}, {7'b0, int_out}, 8'h00);
    chk({tag, " rst vval"}, {7'b0, vector_valid}, 8'h00);
    chk({tag, " rst vec"}, vector_out, 8'h00);
    chk({tag, " rst isr"}, isr, 8'h00);
    chk({tag, " rst irr"}, irr, 8'h00);
    chk({tag, " rst lp"}, {5'b0, dbg_lowest_prio}, 8'h07);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  // ---------------- behavioural reference model ----------------
  int         m_state;  // 0 waiting, 1 INT raised, 2 first INTA seen
  logic [7:0] m_irr, m_isr, m_vec;
  logic [2:0] m_lp;
  int         m_grant;
  bit         m_spur;
  logic       m_int, m_vval;

  function automatic int rank(input logic [2:0] lp, input int lvl);
    return (lvl - int'(lp) + 7) % 8;  // 0 = highest priority
  endfunction

  task automatic model_reset();
    m_state = 0; m_irr = 8'h00; m_isr = 8'h00; m_vec = 8'h00;
    m_lp = 3'd7; m_grant = 0; m_spur = 1'b0; m_int = 1'b0; m_vval = 1'b0;
  endtask

  task automatic model_step();
    logic [7:0] cand, n_irr, n_isr, n_vec;
    logic [2:0] n_lp;
    int w, e, n_state, n_grant;
    bit ok, n_spur;
    logic n_int;
    cand = m_irr & irr_mask;
    w = -1;
    for (int l = 0; l < 8; l++)
      if (cand[l] && (w < 0 || rank(m_lp, l) < rank(m_lp, w))) w = l;
    ok = (w >= 0);
    if (ok)
      for (int l = 0; l < 8; l++)
        if (m_isr[l] && rank(m_lp, l) <= rank(m_lp, w)) ok = 1'b0;
    e = -1;
    if (eoi_valid) begin
      if (eoi_specific) e = int'(eoi_level);
      else
        for (int l = 0; l < 8; l++)
          if (m_isr[l] && (e < 0 || rank(m_lp, l) < rank(m_lp, e))) e = l;
    end
    n_irr = ir_req; n_isr = m_isr; n_vec = m_vec; n_lp = m_lp;
    n_state = m_state; n_grant = m_grant; n_spur = m_spur; n_int = m_int;
    if (e >= 0) n_isr[e] = 1'b0;
    case (m_state)
      0: if (ok) begin n_state = 1; n_int = 1'b1; end
      1: if (inta_pulse) begin
           n_grant = ok ? w : 7;
           n_spur  = !ok;
           if (ok) begin n_isr[w] = 1'b1; n_irr[w] = 1'b0; end
           n_int = 1'b0;
           n_state = 2;
         end
      default: if (inta_pulse) begin
           n_vec = {BASE, 3'(m_grant)};
           n_state = 0;
           if (aeoi_en && !m_spur) begin
             n_isr[m_grant] = 1'b0;
             if (rotate_en) n_lp = 3'(m_grant);
           end
         end
    endcase
    if (e >= 0 && rotate_en) n_lp = 3'(e);
    m_vval  = (m_state == 2) && inta_pulse;
    m_irr = n_irr; m_isr = n_isr; m_vec = n_vec; m_lp = n_lp;
    m_state = n_state; m_grant = n_grant; m_spur = n_spur; m_int = n_int;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [7:0] req, mask;
    logic       inta, eoi, spec;
    logic [2:0] lvl;
    logic       e_int;
    logic [7:0] e_isr, e_irr;
    logic       e_vval;
    logic [7:0] e_vec;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] req, input logic [7:0] mask,
                              input logic inta, input logic eoi, input logic spec,
                              input logic [2:0] lvl, input logic e_int,
                              input logic [7:0] e_isr, input logic [7:0] e_irr,
                              input logic e_vval, input logic [7:0] e_vec);
    vec_t v;
    v.req = req; v.mask = mask; v.inta = inta; v.eoi = eoi; v.spec = spec;
    v.lvl = lvl; v.e_int = e_int; v.e_isr = e_isr; v.e_irr = e_irr;
    v.e_vval = e_vval; v.e_vec = e_vec;
    return v;
  endfunction

  vec_t tbl[23];

  initial begin
    // IR3+IR5, deliver IR3
    tbl[0]  = mk(8'h28, 8'hFF, N, N, N, 3'd0, N, 8'h00, 8'h28, N, 8'h00);
    tbl[1]  = mk(8'h28, 8'hFF, N, N, N, 3'd0, Y, 8'h00, 8'h28, N, 8'h00);
    tbl[2]  = mk(8'h20, 8'hFF, Y, N, N, 3'd0, N, 8'h08, 8'h20, N, 8'h00);
    tbl[3]  = mk(8'h20, 8'hFF, Y, N, N, 3'd0, N, 8'h08, 8'h20, Y, 8'h53);
    tbl[4]  = mk(8'h20, 8'hFF, N, N, N, 3'd0, N, 8'h08, 8'h20, N, 8'h53);
    // IR1 nests over IR3; IR5 waits for EOIs
    tbl[5]  = mk(8'h22, 8'hFF, N, N, N, 3'd0, N, 8'h08, 8'h22, N, 8'h53);
    tbl[6]  = mk(8'h22, 8'hFF, N, N, N, 3'd0, Y, 8'h08, 8'h22, N, 8'h53);
    tbl[7]  = mk(8'h20, 8'hFF, Y, N, N, 3'd0, N, 8'h0A, 8'h20, N, 8'h53);
    tbl[8]  = mk(8'h20, 8'hFF, Y, N, N, 3'd0, N, 8'h0A, 8'h20, Y, 8'h51);
    tbl[9]  = mk(8'h20, 8'hFF, N, Y, N, 3'd0, N, 8'h08, 8'h20, N, 8'h51);
    tbl[10] = mk(8'h20, 8'hFF, N, N, N, 3'd0, N, 8'h08, 8'h20, N, 8'h51);
    tbl[11] = mk(8'h20, 8'hFF, N, Y, N, 3'd0, N, 8'h00, 8'h20, N, 8'h51);
    tbl[12] = mk(8'h20, 8'hFF, N, N, N, 3'd0, Y, 8'h00, 8'h20, N, 8'h51);
    tbl[13] = mk(8'h00, 8'hFF, Y, N, N, 3'd0, N, 8'h20, 8'h00, N, 8'h51);
    tbl[14] = mk(8'h00, 8'hFF, Y, N, N, 3'd0, N, 8'h20, 8'h00, Y, 8'h55);
    tbl[15] = mk(8'h00, 8'hFF, N, Y, Y, 3'd5, N, 8'h00, 8'h00, N, 8'h55);
    // masked IR0, then unmasked
    tbl[16] = mk(8'h01, 8'hFE, N, N, N, 3'd0, N, 8'h00, 8'h01, N, 8'h55);
    tbl[17] = mk(8'h01, 8'hFE, N, N, N, 3'd0, N, 8'h00, 8'h01, N, 8'h55);
    tbl[18] = mk(8'h01, 8'hFE, N, N, N, 3'd0, N, 8'h00, 8'h01, N, 8'h55);
    tbl[19] = mk(8'h01, 8'hFF, N, N, N, 3'd0, Y, 8'h00, 8'h01, N, 8'h55);
    tbl[20] = mk(8'h00, 8'hFF, Y, N, N, 3'd0, N, 8'h01, 8'h00, N, 8'h55);
    tbl[21] = mk(8'h00, 8'hFF, Y, N, N, 3'd0, N, 8'h01, 8'h00, Y, 8'h50);
    tbl[22] = mk(8'h00, 8'hFF, N, Y, N, 3'd0, N, 8'h00, 8'h00, N, 8'h50);
  end

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0; ir_req = 8'h00; irr_mask = 8'hFF; aeoi_en = 1'b0;
    rotate_en = 1'b0; vector_base = BASE;
    idle_inputs();
    #12;
    do_reset("init");

    for (int i = 0; i < 23; i++) begin
      ir_req = tbl[i].req; irr_mask = tbl[i].mask; inta_pulse = tbl[i].inta;
      eoi_valid = tbl[i].eoi; eoi_specific = tbl[i].spec; eoi_level = tbl[i].lvl;
      tick();
      chk($sformatf("row%0d int", i), {7'b0, int_out}, {7'b0, tbl[i].e_int});
      chk($sformatf("row%0d isr", i), isr, tbl[i].e_isr);
      chk($sformatf("row%0d irr", i), irr, tbl[i].e_irr);
      chk($sformatf("row%0d vval", i), {7'b0, vector_valid}, {7'b0, tbl[i].e_vval});
      chk($sformatf("row%0d vec", i), vector_out, tbl[i].e_vec);
    end
    idle_inputs();

    // Spurious: IR2 withdrawn before the first INTA
    ir_req = 8'h04; tick(); tick();
    chk("spur int up", {7'b0, int_out}, 8'h01);
    ir_req = 8'h00; tick();
    chk("spur int held", {7'b0, int_out}, 8'h01);
    inta_pulse = 1'b1; tick();
    chk("spur isr1", isr, 8'h00);
    tick();
    chk("spur vval", {7'b0, vector_valid}, 8'h01);
    chk("spur vec", vector_out, {BASE, 3'd7});
    chk("spur isr2", isr, 8'h00);
    inta_pulse = 1'b0;

    // AEOI + rotation: IR0 then IR4 even with IR0 re-raised
    aeoi_en = 1'b1; rotate_en = 1'b1; ir_req = 8'h11; tick(); tick();
    chk("aeoi int", {7'b0, int_out}, 8'h01);
    inta_pulse = 1'b1; ir_req = 8'h10; tick();
    chk("aeoi isr1", isr, 8'h01);
    ir_req = 8'h11; tick();
    chk("aeoi vec0", vector_out, {BASE, 3'd0});
    chk("aeoi isr0", isr, 8'h00);
    chk("aeoi lp0", {5'b0, dbg_lowest_prio}, 8'h00);
    inta_pulse = 1'b0; tick();
    chk("aeoi int2", {7'b0, int_out}, 8'h01);
    inta_pulse = 1'b1; tick();
    chk("aeoi isr4", isr, 8'h10);
    ir_req = 8'h00; tick();
    chk("aeoi vec4", vector_out, {BASE, 3'd4});
    chk("aeoi isr clr", isr, 8'h00);
    chk("aeoi lp4", {5'b0, dbg_lowest_prio}, 8'h04);
    inta_pulse = 1'b0; aeoi_en = 1'b0; rotate_en = 1'b0; tick();

    // Specific EOI with rotation, then reset between INTA pulses
    do_reset("seq6");
    ir_req = 8'h20; tick(); tick();
    inta_pulse = 1'b1; ir_req = 8'h00; tick(); tick();
    chk("s6 vec5", vector_out, {BASE, 3'd5});
    inta_pulse = 1'b0; ir_req = 8'h01; tick(); tick();
    chk("s6 nest int", {7'b0, int_out}, 8'h01);
    inta_pulse = 1'b1; ir_req = 8'h00; tick();
    chk("s6 isr21", isr, 8'h21);
    tick();
    inta_pulse = 1'b0; eoi_valid = 1'b1; eoi_specific = 1'b1; eoi_level = 3'd5;
    rotate_en = 1'b1; tick();
    chk("s6 isr01", isr, 8'h01);
    chk("s6 lp5", {5'b0, dbg_lowest_prio}, 8'h05);
    idle_inputs(); rotate_en = 1'b0; ir_req = 8'hC0; tick(); tick();
    chk("s6 int6", {7'b0, int_out}, 8'h01);
    inta_pulse = 1'b1; ir_req = 8'h00; tick();
    chk("s6 isr41", isr, 8'h41);
    inta_pulse = 1'b1;
    do_reset("s6 mid");
    inta_pulse = 1'b1; tick();
    chk("s6 no vval", {7'b0, vector_valid}, 8'h00);
    chk("s6 post int", {7'b0, int_out}, 8'h00);
    inta_pulse = 1'b0;

    // Random traffic against the reference model
    do_reset("rand");
    model_reset();
    aeoi_en = 1'b0; rotate_en = 1'b0; irr_mask = 8'hFF; ir_req = 8'h00;
    for (int c = 0; c < 2500; c++) begin
      if ($urandom_range(0, 799) == 0) begin
        do_reset("rand mid");
        model_reset();
      end
      if ($urandom_range(0, 3) == 0) ir_req = 8'($urandom) & 8'($urandom);
      if ($urandom_range(0, 15) == 0)
        irr_mask = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      if ($urandom_range(0, 63) == 0) aeoi_en = ~aeoi_en;
      if ($urandom_range(0, 63) == 0) rotate_en = ~rotate_en;
      inta_pulse   = (m_state != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      eoi_valid    = ($urandom_range(0, 7) == 0);
      eoi_specific = 1'($urandom_range(0, 1));
      eoi_level    = 3'($urandom_range(0, 7));
      model_step();
      tick();
      chk($sformatf("rnd%0d int", c), {7'b0, int_out}, {7'b0, m_int});
      chk($sformatf("rnd%0d isr", c), isr, m_isr);
      chk($sformatf("rnd%0d irr", c), irr, m_irr);
      chk($sformatf("rnd%0d vval", c), {7'b0, vector_valid}, {7'b0, m_vval});
      chk($sformatf("rnd%0d vec", c), vector_out, m_vec);
      chk($sformatf("rnd%0d lp", c), {5'b0, dbg_lowest_prio}, {5'b0, m_lp});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
